// File: rtl/cdc_synchron.sv
// cdc_synchron
// ------------
// Single-bit clock-domain-crossing synchronizer with edge detection.
// An asynchronous input (for example SPI MISO from an external slave) is
// brought into the sysClk_i domain through a STAGES-deep flop chain. The
// synchronized level is then compared against a one-cycle history flop to
// produce single-cycle rising and falling strobes.
//
// Parameters:
//   STAGES    - synchronizer depth, 2..4
//   RESET_VAL - value loaded into every chain flop and the history flop on reset
//
// Ports:
//   sysClk_i  - destination-domain clock, all flops on the rising edge
//   reset     - asynchronous, active-high reset
//   async_i   - asynchronous input, no timing relationship to sysClk_i
//   sync_o    - synchronized level (last chain stage)
//   rising_o  - one-cycle strobe in the first cycle sync_o is 1 after being 0
//   falling_o - one-cycle strobe in the first cycle sync_o is 0 after being 1

module cdc_synchron #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic sysClk_i,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rising_o,
  output logic falling_o
);

  // A single flop gives no settling time for metastability, and more than
  // four only adds latency, so anything outside 2..4 stops elaboration.
  if (STAGES < 2 || STAGES > 4) begin : gBadStages
    $error("cdc_synchron: STAGES must be in 2..4");
  end

  // Chain flops are marked so that place-and-route keeps them adjacent and
  // synthesis never retimes or merges them.
  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  logic hist_q;
  logic hist_d;

  // Shift the chain by one: only stage 0 ever sees the raw input, and no
  // other logic taps the input or any intermediate stage.
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], async_i};
    hist_d  = stage_q[STAGES-1];
  end

  // Reset loads RESET_VAL everywhere, including the history flop, so the
  // first cycle after release never sees a spurious edge.
  always_ff @(posedge sysClk_i or posedge reset) begin
    if (reset) begin
      stage_q <= {STAGES{RESET_VAL}};
      hist_q  <= RESET_VAL;
    end else begin
      stage_q <= stage_d;
      hist_q  <= hist_d;
    end
  end

  // Strobes are decoded purely from flop outputs, so they are glitch-free
  // and mutually exclusive by construction.
  assign sync_o    = stage_q[STAGES-1];
  assign rising_o  = stage_q[STAGES-1] & ~hist_q;
  assign falling_o = ~stage_q[STAGES-1] & hist_q;

endmodule

// File: tb/tb_cdc_synchron.sv
// tb_cdc_synchron
// ---------------
// Directed bench for cdc_synchron. Two instances share one clock:
//   dutA - STAGES=2, RESET_VAL=0
//   dutB - STAGES=3, RESET_VAL=1
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, well away from the active edge.

module tb_cdc_synchron;

  logic clk;
  logic resetA, resetB;
  logic asyncA, asyncB;
  logic syncA, risingA, fallingA;
  logic syncB, risingB, fallingB;

  int total;
  int bad;

  cdc_synchron #(.STAGES(2), .RESET_VAL(1'b0)) dutA (
    .sysClk_i (clk),
    .reset    (resetA),
    .async_i  (asyncA),
    .sync_o   (syncA),
    .rising_o (risingA),
    .falling_o(fallingA)
  );

  cdc_synchron #(.STAGES(3), .RESET_VAL(1'b1)) dutB (
    .sysClk_i (clk),
    .reset    (resetB),
    .async_i  (asyncB),
    .sync_o   (syncB),
    .rising_o (risingB),
    .falling_o(fallingB)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the chosen instance's input, then advance one clock.
  task automatic applyStimulus(input bit which, input logic val);
    if (which) asyncB = val;
    else       asyncA = val;
    tick();
  endtask

  // Compare all three outputs of the chosen instance against expectations.
  task automatic checkOutput(input string tag, input bit which,
                             input logic expSync, input logic expRise,
                             input logic expFall);
    logic s, r, f;
    s = which ? syncB    : syncA;
    r = which ? risingB  : risingA;
    f = which ? fallingB : fallingA;
    total++;
    assert (s === expSync) else begin
      bad++;
      $error("[TB] FAIL %s sync: got %b want %b", tag, s, expSync);
    end
    total++;
    assert (r === expRise) else begin
      bad++;
      $error("[TB] FAIL %s rising: got %b want %b", tag, r, expRise);
    end
    total++;
    assert (f === expFall) else begin
      bad++;
      $error("[TB] FAIL %s falling: got %b want %b", tag, f, expFall);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetA = 1'b0;
    resetB = 1'b0;
    asyncA = 1'b0;
    asyncB = 1'b1;

    // Async reset assertion, checked before any clock edge.
    #1;
    resetA = 1'b1;
    resetB = 1'b1;
    #1;
    checkOutput("A rst async", 0, 1'b0, 1'b0, 1'b0);
    checkOutput("B rst async", 1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("A rst held", 0, 1'b0, 1'b0, 1'b0);
    checkOutput("B rst held", 1, 1'b1, 1'b0, 1'b0);

    // Release reset and confirm quiet outputs for 5 cycles.
    resetA = 1'b0;
    resetB = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("A post-rst", 0, 1'b0, 1'b0, 1'b0);
      checkOutput("B post-rst", 1, 1'b1, 1'b0, 1'b0);
    end

    // A: 0->1, sampled on edge k, visible after edge k+1 with a rising strobe.
    applyStimulus(0, 1'b1);
    checkOutput("A rise k", 0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("A rise k+1", 0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("A rise k+2", 0, 1'b1, 1'b0, 1'b0);

    // A: hold high, no strobes.
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("A hold1", 0, 1'b1, 1'b0, 1'b0);
    end

    // A: 1->0 gives a single falling strobe two edges after sampling.
    applyStimulus(0, 1'b0);
    checkOutput("A fall k", 0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("A fall k+1", 0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("A fall k+2", 0, 1'b0, 1'b0, 1'b0);

    // A: toggle 1,0,1,0 each held one period; strobes alternate each cycle.
    applyStimulus(0, 1'b1);
    checkOutput("A tog0", 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0);
    checkOutput("A tog1", 0, 1'b1, 1'b1, 1'b0);
    applyStimulus(0, 1'b1);
    checkOutput("A tog2", 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0);
    checkOutput("A tog3", 0, 1'b1, 1'b1, 1'b0);
    applyStimulus(0, 1'b0);
    checkOutput("A tog4", 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0);
    checkOutput("A tog5", 0, 1'b0, 1'b0, 1'b0);

    // A: reset while a 0->1 sits in stage 0; transition is discarded.
    applyStimulus(0, 1'b1);
    checkOutput("A inflight", 0, 1'b0, 1'b0, 1'b0);
    resetA = 1'b1;
    #1;
    checkOutput("A midrst async", 0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("A midrst held", 0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("A midrst held2", 0, 1'b0, 1'b0, 1'b0);
    resetA = 1'b0;
    tick();
    checkOutput("A rel+1", 0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("A rel+2", 0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("A rel+3", 0, 1'b1, 1'b0, 1'b0);

    // B: STAGES=3, 1->0 gives a falling strobe three edges after sampling.
    applyStimulus(1, 1'b0);
    checkOutput("B fall k", 1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("B fall k+1", 1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("B fall k+2", 1, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("B fall k+3", 1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
